hilo_muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer owning the HI/LO register pair for the MIPS datapath.
- Executes MULT/MULTU/MADD/MSUB through a fixed-latency multiply path.
- Executes DIV/DIVU with a 32-iteration restoring divider; services MTHI/MTLO writes directly.
- Exports Busy so the hazard/stall logic can freeze the pipeline while a mul/div is in flight; MFHI/MFLO read HI/LO outputs directly.

---
 rtl/hilo_muldiv_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_hilo_muldiv_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
// Owns the HI/LO register pair. It runs multiply-class ops (MULT/MULTU/MADD/MSUB)
// through a fixed-latency path and DIV/DIVU through a 32-step restoring divider.
// It also services MTHI/MTLO writes directly.
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous active-high reset
//   Start      request strobe, accepted in IDLE or FIN
//   Op[2:0]    0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO
//   A, B       rs / rt operands
//   Busy       high while a mul/div is in flight (MUL, DIV, FIX)
//   Done       one-cycle pulse after a commit or a div-by-zero abort
//   DivByZero  pulses together with Done when the divisor was zero
//   HI, LO     architectural HI/LO registers
module hilo_muldiv_sequencer #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_FIN} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_ma, r_mb;
  logic [1:0]  r_mop;
  logic [31:0] r_rem, r_quo, r_dvsr;
  logic        r_qneg, r_rneg, r_dbz;

  logic        w_accept, w_is_mul, w_is_div, w_div_signed, w_b_zero;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_mul_signed;
  logic [63:0] w_ea, w_eb, w_prod, w_mul_res;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;

  assign w_accept     = Start && (r_state == S_IDLE || r_state == S_FIN);
  assign w_is_mul     = ~Op[2];
  assign w_is_div     = Op[2] & ~Op[1];
  assign w_div_signed = ~Op[0];
  assign w_b_zero     = (B == '0);
  assign w_a_neg      = w_div_signed & A[31];
  assign w_b_neg      = w_div_signed & B[31];
  assign w_a_mag      = w_a_neg ? -A : A;
  assign w_b_mag      = w_b_neg ? -B : B;

  // Sign/zero-extend to 64 bits so one 64x64 product (mod 2^64) covers both
  // signed and unsigned forms.
  assign w_mul_signed = (r_mop != 2'd1);
  assign w_ea         = {{32{w_mul_signed & r_ma[31]}}, r_ma};
  assign w_eb         = {{32{w_mul_signed & r_mb[31]}}, r_mb};
  assign w_prod       = w_ea * w_eb;

  always_comb begin
    case (r_mop)
      2'd2:    w_mul_res = {r_hi, r_lo} + w_prod;
      2'd3:    w_mul_res = {r_hi, r_lo} - w_prod;
      default: w_mul_res = w_prod;
    endcase
  end

  // Restoring step: the remainder is kept below the divisor, so a 32-bit
  // difference is exact whenever the trial subtract succeeds.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  assign w_diff  = w_shift[31:0] - r_dvsr;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        w_next = S_IDLE;
        if (w_accept) begin
          if (w_is_mul)      w_next = S_MUL;
          else if (w_is_div) w_next = w_b_zero ? S_FIN : S_DIV;
        end
      end
      S_MUL:   if (r_cnt == '0) w_next = S_FIN;
      S_DIV:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_FIN;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    DivByZero = 1'b0;
    case (r_state)
      S_MUL, S_DIV, S_FIX: Busy = 1'b1;
      S_FIN: begin
        Done      = 1'b1;
        DivByZero = r_dbz;
      end
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_ma   <= '0;
      r_mb   <= '0;
      r_mop  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_dbz <= w_accept & w_is_div & w_b_zero;
      case (r_state)
        S_IDLE, S_FIN: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_ma  <= A;
              r_mb  <= B;
              r_mop <= Op[1:0];
              r_cnt <= MUL_LAST;
            end else if (w_is_div) begin
              if (!w_b_zero) begin
                r_quo  <= w_a_mag;
                r_dvsr <= w_b_mag;
                r_rem  <= '0;
                r_qneg <= w_a_neg ^ w_b_neg;
                r_rneg <= w_a_neg;
                r_cnt  <= 5'd31;
              end
            end else if (!Op[0]) begin
              r_hi <= A;
            end else begin
              r_lo <= A;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == '0) {r_hi, r_lo} <= w_mul_res;
          else             r_cnt <= r_cnt - 5'd1;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_ge};
          if (r_cnt != '0) r_cnt <= r_cnt - 5'd1;
        end
        S_FIX: begin
          r_lo <= r_qneg ? -r_quo : r_quo;
          r_hi <= r_rneg ? -r_rem : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
module tb_hilo_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy, Done, DivByZero;
  logic [31:0] HI, LO;

  hilo_muldiv_sequencer #(.MUL_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && Done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, HI, e.hi);
          chk({e.name, "_lo"}, LO, e.lo);
          chk({e.name, "_dbz"}, {31'd0, DivByZero}, {31'd0, e.dbz});
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0; A = '0; B = '0;
  endtask

  task automatic expect_res(input string name, input logic [31:0] hi, input logic [31:0] lo,
                            input logic dbz);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.dbz = dbz;
    exp_q.push_back(e);
  endtask

  // Counts cycles (sampled at negedge) until Done, bounded.
  task automatic wait_done(output int n, output int busy_n);
    n = 0; busy_n = 0;
    while (!Done && n < 200) begin
      if (Busy) busy_n++;
      @(negedge Clk);
      n++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                     input logic dbz, input int lat);
    int n, bn;
    expect_res(name, hi, lo, dbz);
    issue(op, a, b);
    wait_done(n, bn);
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_cycles"}, bn, lat);
  endtask

  initial begin
    int n, bn;
    #12;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_flags", {29'd0, Busy, Done, DivByZero}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    run("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 4);
    run("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0, 4);

    issue(3'd6, 32'd0, 32'd0);
    chk("mthi", HI, 32'd0);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    issue(3'd7, 32'd10, 32'd0);
    chk("mtlo", LO, 32'd10);
    run("madd", 3'd2, 32'd5, 32'd6, 32'h0, 32'd40, 1'b0, 4);
    run("msub", 3'd3, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF7, 1'b0, 4);

    run("div_neg",  3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run("divu",     3'd5, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);

    issue(3'd6, 32'h11, 32'd0);
    issue(3'd7, 32'h22, 32'd0);
    run("div_zero", 3'd4, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 0);

    // Start during iteration 10 must be ignored.
    expect_res("divu_ignore", 32'd2, 32'd14, 1'b0);
    issue(3'd5, 32'd100, 32'd7);
    repeat (10) @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'd3; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(n, bn);
    chk("divu_ignore_latency", n, 32'd22);

    // Start in the FIN cycle is accepted back-to-back.
    expect_res("multu_fin", 32'd1, 32'd0, 1'b0);
    Start = 1'b1; Op = 3'd1; A = 32'h10000; B = 32'h10000;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(n, bn);
    chk("multu_fin_latency", n, 32'd4);

    // Reset mid-divide abandons the operation.
    issue(3'd5, 32'd100, 32'd7);
    repeat (19) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rst_mid_hi", HI, 32'h0);
    chk("rst_mid_lo", LO, 32'h0);
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    chk("rst_no_done_pending", exp_q.size(), 32'd0);

    run("mult_after_rst", 3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 4);

    repeat (3) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
